acc_out_port: RTL and testbench
===============================

# acc_out_port

Output-direction companion to the accumulator's `in` load path. The CPU writes the current accumulator value into a small FIFO with a one-cycle strobe. An external consumer drains the FIFO through a valid/ready handshake. Status outputs (`full`, `empty`, `count`, sticky `overflow`) feed back to the control unit so that programs can poll before writing.

## Interface
Parameters:
- `WIDTH`, 16, data word width; matches the accumulator and bus.
- `DEPTH`, 4, number of FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the falling edge, the same edge as the accumulator.
- `reset`  in  1  reset, synchronous, active-high.
- `wr`  in  1  CPU write strobe; pushes `data` on this edge.
- `data`  in  WIDTH  accumulator output value.
- `out_data`  out  WIDTH  head-of-FIFO word; 0 while empty.
- `out_valid`  out  1  head word present; equals `!empty`.
- `out_ready`  in  1  consumer accepts the head word on this edge when `out_valid` is 1.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag; a write was dropped.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- Storage: circular buffer of DEPTH × WIDTH.
  - Write pointer and read pointer are each clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is held in a separate `count` register.
- Push condition: `wr && (!full || pop)`, where `pop = out_valid && out_ready`.
  - On push, `data` is written at the write pointer and the write pointer increments.
- Pop condition: `pop`. The read pointer increments.
- Count update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Full and pop in the same edge with `wr` asserted: the write is accepted. `count` stays DEPTH. No overflow is raised.
- Empty with `wr` and `out_ready` both asserted: no pop occurs, because `out_valid` is 0. The write is accepted and `count` becomes 1.
- Drop condition: `wr && full && !pop`. The FIFO contents and pointers are unchanged, and `overflow` is set to 1.
- `overflow` clearing:
  - `clr_ovf` clears it to 0.
  - If a drop and `clr_ovf` occur on the same edge, set wins and `overflow` = 1.
- `out_data` is combinational from the storage at the read pointer, gated to 0 when `empty`.
- `full`, `empty`, `out_valid` and `overflow` are combinational from `count` or registered state only. There is no path from `wr` or `out_ready` to any output.
- Reset:
  - Pointers = 0, `count` = 0, `overflow` = 0.
  - Storage contents are not cleared.
  - Outputs after reset: `out_valid` = 0, `out_data` = 0, `empty` = 1, `full` = 0.
  - `reset` has priority over `wr`, `out_ready` and `clr_ovf` on the same edge.
  - Reset mid-stream discards all queued words.

## Timing
- Write-to-visible latency: one edge.
  - A word pushed into an empty FIFO at edge N appears on `out_data` with `out_valid` = 1 immediately after edge N.
- Throughput: one push and one pop per edge, sustained.
- Handshake:
  - The consumer samples `out_data` on the same falling edge on which it sees `out_valid && out_ready`.
  - `out_valid` never drops without a pop or a reset.
  - `out_data` is stable while `out_valid && !out_ready`.
- Status visibility: `full`, `count` and `overflow` reflect the edge just taken. A CPU `wr` in the instruction after polling sees current status.

## Test plan
- Reset then idle:
  - `reset` = 1 for one edge, then 0 → `count` = 0, `empty` = 1, `out_valid` = 0, `out_data` = 16'h0000, `overflow` = 0.
- Fill and drain, DEPTH = 4:
  - Write 16'h1111, 16'h2222, 16'h3333, 16'h4444 with `out_ready` = 0 → `full` = 1, `count` = 4, `out_data` = 16'h1111.
  - Then `out_ready` = 1 for 4 edges → words pop in order, then `empty` = 1.
- Overflow and clear:
  - When full, write 16'hDEAD with `out_ready` = 0 → `overflow` = 1, `count` = 4, head still 16'h1111.
  - Drop and `clr_ovf` on the same edge → `overflow` = 1.
  - `clr_ovf` alone → `overflow` = 0.
- Simultaneous push and pop:
  - When full, `wr` with 16'h5555 and `out_ready` = 1 → `count` = 4, `overflow` = 0.
  - After 4 further pops, the last word is 16'h5555.
- Wrap-around:
  - 10 interleaved push/pop cycles carrying values 1..10 → consumer receives 1..10 in order.
  - `count` never exceeds 1, and both pointers wrap at least twice.
- Reset mid-stream:
  - With 3 words queued, assert `reset` together with `wr` = 1 → `count` = 0, `out_valid` = 0. The `wr` on that edge is ignored.

Source files
------------

// File: rtl/acc_out_port.sv
// acc_out_port
//
// Output-direction companion to the accumulator load path. The CPU pushes the
// accumulator value into a small circular FIFO with a one-cycle write strobe;
// an external consumer drains it through a valid/ready handshake. Status
// outputs let programs poll before writing.
//
// All state updates on the falling edge of clk, matching the accumulator.
//
// Parameters:
//   WIDTH      data word width
//   DEPTH      number of FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        clock (falling-edge active)
//   reset      synchronous, active-high reset; clears pointers, count, overflow
//   wr         CPU write strobe; pushes data on this edge if accepted
//   data       accumulator value to push
//   out_data   head-of-FIFO word, 0 while empty
//   out_valid  head word present (== !empty)
//   out_ready  consumer accepts the head word on this edge when out_valid
//   full       count == DEPTH
//   empty      count == 0
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: a write was dropped because the FIFO was full
//   clr_ovf    clears overflow (a same-edge drop still sets it)

module acc_out_port #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           data,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntZero = '0;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  // Storage is deliberately left out of reset; only the pointers and count
  // decide what is visible.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic push;
  logic pop;
  logic drop;

  // ---------------------------------------------------------------------------
  // Status, derived from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    full      = (count_q == CntFull);
    empty     = (count_q == CntZero);
    out_valid = !empty;
    count     = count_q;
    overflow  = overflow_q;
    out_data  = empty ? '0 : mem_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // A write while full is still accepted if the head leaves on the same edge,
  // so the slot it frees is reused immediately.
  always_comb begin
    pop  = out_valid && out_ready;
    push = wr && (!full || pop);
    drop = wr && full && !pop;
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // Set beats clear so a drop is never lost to a concurrent clear.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers (falling edge, synchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write; gated by reset so a write on a reset edge leaves no trace
  // even in the array.
  always_ff @(negedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

endmodule

// File: tb/tb_acc_out_port.sv
// Self-checking bench for acc_out_port (WIDTH = 16, DEPTH = 4).
// Inputs change 1 time unit after each falling edge; the DUT acts on falling
// edges. Expected popped words are queued by the stimulus and checked by a
// monitor branch at the rising edge, when an accepted word is presented.

module tb_acc_out_port;

  localparam int unsigned Width = 16;
  localparam int unsigned Depth = 4;

  logic             clk;
  logic             reset;
  logic             wr;
  logic [Width-1:0] data;
  logic [Width-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             overflow;
  logic             clr_ovf;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [Width-1:0] exp_q [$];

  acc_out_port #(
    .WIDTH(Width),
    .DEPTH(Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .data     (data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Apply inputs for one falling edge, then return just after it.
  task automatic step(input logic w, input logic [Width-1:0] d, input logic r,
                      input logic c, input logic rs);
    wr        = w;
    data      = d;
    out_ready = r;
    clr_ovf   = c;
    reset     = rs;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_w(input logic [Width-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  // Pop with an expected head word, optionally pushing on the same edge.
  task automatic pop_w(input logic [Width-1:0] want, input logic w, input logic [Width-1:0] d);
    exp_q.push_back(want);
    step(w, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_status(input string tag, input logic [2:0] c, input logic f,
                            input logic e, input logic o);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_full"}, 32'(full), 32'(f));
    chk({tag, "_empty"}, 32'(empty), 32'(e));
    chk({tag, "_valid"}, 32'(out_valid), 32'(!e));
    chk({tag, "_ovf"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    wr = 1'b0; data = '0; out_ready = 1'b0; clr_ovf = 1'b0; reset = 1'b1;
    n_cmp = 0;
    n_bad = 0;

    fork
      begin : monitor
        forever begin
          @(posedge clk);
          if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL pop_unexpected: got %0h, required no pop (t=%0t)", out_data, $time);
            end else begin
              chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
          end
        end
      end
      begin : stimulus
        // Reset for one edge, then idle.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        chk_status("rst", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("rst_data", 32'(out_data), 32'h0);

        // Fill.
        push_w(16'h1111);
        chk("first_visible", 32'(out_data), 32'h1111);
        chk("first_count", 32'(count), 32'd1);
        push_w(16'h2222);
        push_w(16'h3333);
        push_w(16'h4444);
        chk_status("fill", 3'd4, 1'b1, 1'b0, 1'b0);
        chk("fill_head", 32'(out_data), 32'h1111);

        // Overflow: drop sets, clear clears, drop+clear sets.
        push_w(16'hDEAD);
        chk_status("drop", 3'd4, 1'b1, 1'b0, 1'b1);
        chk("drop_head", 32'(out_data), 32'h1111);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(overflow), 32'h0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
        chk("drop_and_clr", 32'(overflow), 32'h1);
        chk("drop_and_clr_head", 32'(out_data), 32'h1111);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("clr_again", 32'(overflow), 32'h0);

        // Drain in order.
        pop_w(16'h1111, 1'b0, '0);
        chk("drain1_count", 32'(count), 32'd3);
        pop_w(16'h2222, 1'b0, '0);
        pop_w(16'h3333, 1'b0, '0);
        pop_w(16'h4444, 1'b0, '0);
        chk_status("drained", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("drained_data", 32'(out_data), 32'h0);

        // Empty with wr and out_ready: no pop, write accepted.
        step(1'b1, 16'h0A01, 1'b1, 1'b0, 1'b0);
        chk("empty_wr_rdy_count", 32'(count), 32'd1);
        push_w(16'h0A02);
        push_w(16'h0A03);
        push_w(16'h0A04);
        chk("refill_full", 32'(full), 32'h1);

        // Full with simultaneous push and pop.
        pop_w(16'h0A01, 1'b1, 16'h5555);
        chk_status("pushpop_full", 3'd4, 1'b1, 1'b0, 1'b0);
        pop_w(16'h0A02, 1'b0, '0);
        pop_w(16'h0A03, 1'b0, '0);
        pop_w(16'h0A04, 1'b0, '0);
        pop_w(16'h5555, 1'b0, '0);
        chk("after_5555_empty", 32'(empty), 32'h1);

        // Wrap-around: 1..10 streamed through with occupancy held at 1.
        push_w(16'd1);
        for (int i = 2; i <= 10; i++) begin
          pop_w(16'(i - 1), 1'b1, 16'(i));
          chk("wrap_count", 32'(count), 32'd1);
        end
        pop_w(16'd10, 1'b0, '0);
        chk("wrap_empty", 32'(empty), 32'h1);

        // Reset mid-stream with a concurrent write.
        push_w(16'h00B1);
        push_w(16'h00B2);
        push_w(16'h00B3);
        chk("mid_count", 32'(count), 32'd3);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        chk_status("mid_rst", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        idle();
        chk("post_rst_count", 32'(count), 32'd0);
        push_w(16'h7777);
        pop_w(16'h7777, 1'b0, '0);
        chk("final_empty", 32'(empty), 32'h1);
        idle();
      end
    join_any
    disable fork;

    chk("pending_pops", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
